axi_stream_rr_arbiter: RTL and testbench

- Shares one 8-bit AXI-style register stage between NUM_REQ upstream masters using round-robin, packet-locked arbitration.
- Once a requester is granted, it keeps the grant until its last beat is accepted. No packet interleaving occurs on the output.
- Sits in front of the 8-bit register slice and drives its master-side data/valid/last.
- The output is registered, with ready propagated back to the granted requester only.

---
 rtl/axi_arb_pkg.sv | 8 +
 rtl/rr_priority_pick.sv | 24 ++
 rtl/axi_stream_rr_arbiter.sv | 63 ++++++
 tb/tb_axi_stream_rr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM encoding, default beat width and round-robin index helper for the stream arbiter
package axi_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;
  localparam int DEF_DATA_W = 8;
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational search for the first set request at or after ptr, wrapping around
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  int j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx = j[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// axi_stream_rr_arbiter: packet-locked round-robin mux of NUM_REQ beat streams into one registered output stage
module axi_stream_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         s_data,
  output logic                      s_valid,
  output logic                      s_last,
  input  logic                      s_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic [15:0]               pkt_count
);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, pick_idx;
  logic found, slot_free, accept, beat_last;
  logic [DATA_W-1:0] beat;
  rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req(req_valid), .ptr(ptr), .found(found), .idx(pick_idx)
  );
  // the output slot can take a new beat when empty or being drained this cycle
  assign slot_free = !s_valid || s_ready;
  assign accept    = (state == ST_LOCKED) && req_valid[grant_idx] && slot_free;
  assign beat      = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign beat_last = req_last[grant_idx];
  assign busy      = (state == ST_LOCKED);
  assign req_ready = (state == ST_LOCKED && slot_free) ? (NUM_REQ'(1) << grant_idx) : '0;
  always_comb begin
    state_n = state;
    state_n = (state == ST_IDLE) ? (found ? ST_LOCKED : ST_IDLE)
                                 : ((accept && beat_last) ? ST_IDLE : ST_LOCKED);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      s_data    <= '0;
      s_valid   <= 1'b0;
      s_last    <= 1'b0;
      pkt_count <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && found) grant_idx <= pick_idx;
      if (accept) begin
        s_data  <= beat;
        s_last  <= beat_last;
        s_valid <= 1'b1;
      end else if (s_ready) s_valid <= 1'b0;
      if (accept && beat_last) ptr <= IDX_W'(wrap_inc(int'(grant_idx), NUM_REQ));
      if (s_valid && s_ready && s_last) pkt_count <= pkt_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// tb_axi_stream_rr_arbiter: vector table, directed corner sequences and random traffic against a cycle reference model
module tb_axi_stream_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] req_data = '0;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [7:0] s_data;
  logic s_valid, s_last, busy;
  logic s_ready = 1'b0;
  logic [1:0] grant_idx;
  logic [15:0] pkt_count;
  axi_stream_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  // reference model: owner is -1 when no packet is held
  int m_owner = -1, m_ptr = 0;
  logic [1:0] m_g = '0;
  logic m_ov = 1'b0, m_ol = 1'b0, m_ok = 1'b0;
  logic [7:0] m_od = '0;
  logic [15:0] m_cnt = '0;
  // traffic generators
  bit en[4];
  int rem[4];
  logic [7:0] base[4], bc[4];
  logic [7:0] out_q[$];
  int gq[$];
  logic prev_busy = 1'b0;
  typedef struct {
    logic [3:0] v; logic [3:0] l; logic [31:0] d; logic sr;
    logic ev; logic [7:0] ed; logic el; logic [3:0] er; logic eb; logic [1:0] eg; logic [15:0] ec;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [3:0] exp_ready();
    logic [3:0] r = '0;
    if (m_owner >= 0 && (!m_ov || s_ready)) r[m_owner] = 1'b1;
    return r;
  endfunction
  task automatic model_update(output int acc);
    bit room, cons, got;
    acc = -1;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_g = '0; m_ov = 0; m_ol = 0; m_od = '0; m_cnt = '0; m_ok = 1;
      return;
    end
    room = !m_ov || s_ready;
    cons = m_ov && s_ready;
    if (cons && m_ol) m_cnt++;
    if (cons) m_ov = 0;
    if (m_owner < 0) begin
      got = 0;
      for (int k = 0; k < 4; k++)
        if (!got && req_valid[(m_ptr + k) % 4]) begin
          got = 1;
          m_owner = (m_ptr + k) % 4;
          m_g = 2'(m_owner);
        end
    end else if (req_valid[m_owner] && room) begin
      acc = m_owner;
      m_od = req_data[m_owner*8 +: 8];
      m_ol = req_last[m_owner];
      m_ov = 1;
      if (m_ol) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endtask
  task automatic compare_model();
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("grant_idx", 32'(grant_idx), 32'(m_g));
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("s_valid", 32'(s_valid), 32'(m_ov));
    chk("s_data", 32'(s_data), 32'(m_od));
    chk("s_last", 32'(s_last), 32'(m_ol));
    chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
  endtask
  task automatic cyc(input logic r, input logic sr);
    int a;
    @(negedge clk);
    rst = r;
    s_ready = sr;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = en[i] && rem[i] > 0;
      req_last[i] = (rem[i] == 1);
      req_data[i*8 +: 8] = base[i] + bc[i];
    end
    #1;
    if (m_ok) compare_model();
    if (s_valid && s_ready) out_q.push_back(s_data);
    if (busy && !prev_busy) gq.push_back(int'(grant_idx));
    prev_busy = busy;
    @(posedge clk);
    model_update(a);
    if (r) foreach (rem[i]) rem[i] = 0;
    else if (a >= 0) begin
      bc[a]++;
      rem[a]--;
    end
    #1;
  endtask
  task automatic clear_gen();
    foreach (en[i]) begin
      en[i] = 0; rem[i] = 0; bc[i] = '0; base[i] = 8'(i * 64);
    end
  endtask
  initial begin
    int a;
    logic [7:0] bp_exp[3];
    int rr_exp[5];
    tbl[0] = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd0, 16'd0};
    tbl[1] = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0010, 1'b1, 2'd1, 16'd0};
    tbl[2] = '{4'b0010, 4'b0000, 32'h0000_A200, 1'b1, 1'b1, 8'hA1, 1'b0, 4'b0010, 1'b1, 2'd1, 16'd0};
    tbl[3] = '{4'b0010, 4'b0010, 32'h0000_A300, 1'b1, 1'b1, 8'hA2, 1'b0, 4'b0010, 1'b1, 2'd1, 16'd0};
    tbl[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'hA3, 1'b1, 4'b0000, 1'b0, 2'd1, 16'd0};
    tbl[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'hA3, 1'b1, 4'b0000, 1'b0, 2'd1, 16'd1};
    bp_exp = '{8'h10, 8'h11, 8'h12};
    rr_exp = '{0, 1, 2, 3, 0};
    clear_gen();
    // reset then idle
    cyc(1, 1);
    cyc(1, 1);
    repeat (10) cyc(0, 1);
    // single requester, hand-computed vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = 0;
      s_ready = tbl[i].sr;
      req_valid = tbl[i].v;
      req_last = tbl[i].l;
      req_data = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_s_valid", i), 32'(s_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_s_data", i), 32'(s_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_s_last", i), 32'(s_last), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_grant_idx", i), 32'(grant_idx), 32'(tbl[i].eg));
      chk($sformatf("tbl%0d_pkt_count", i), 32'(pkt_count), 32'(tbl[i].ec));
      @(posedge clk);
      model_update(a);
      #1;
    end
    // round-robin fairness with 2-beat packets
    clear_gen();
    cyc(1, 1);
    foreach (en[i]) en[i] = 1;
    gq.delete();
    for (int c = 0; c < 100 && pkt_count != 16'd5; c++) begin
      foreach (rem[i]) if (rem[i] == 0) rem[i] = 2;
      cyc(0, 1);
    end
    chk("rr_pkt_count", 32'(pkt_count), 32'd5);
    chk("rr_grants_seen", 32'(gq.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) if (k < gq.size()) chk($sformatf("rr_grant%0d", k), 32'(gq[k]), 32'(rr_exp[k]));
    // backpressure on requester 2
    clear_gen();
    cyc(1, 1);
    en[2] = 1; rem[2] = 3; base[2] = 8'h10;
    out_q.delete();
    cyc(0, 1);
    cyc(0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0);
      chk("bp_hold_data", 32'(s_data), 32'h10);
      chk("bp_ready2", 32'(req_ready[2]), 32'd0);
    end
    for (int c = 0; c < 20 && out_q.size() < 3; c++) cyc(0, 1);
    repeat (3) cyc(0, 1);
    chk("bp_beats", 32'(out_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) if (k < out_q.size()) chk($sformatf("bp_beat%0d", k), 32'(out_q[k]), 32'(bp_exp[k]));
    // packet lock while owner stalls
    clear_gen();
    cyc(1, 1);
    en[0] = 1; rem[0] = 4; en[3] = 1; rem[3] = 2;
    repeat (3) cyc(0, 1);
    en[0] = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1);
      chk("lock_grant", 32'(grant_idx), 32'd0);
      chk("lock_ready3", 32'(req_ready[3]), 32'd0);
    end
    en[0] = 1;
    a = 0;
    for (int c = 0; c < 20 && a == 0; c++) begin
      cyc(0, 1);
      if (rem[0] == 0 && busy) a = 1;
    end
    chk("lock_next_seen", 32'(a), 32'd1);
    chk("lock_next_grant", 32'(grant_idx), 32'd3);
    // reset in the middle of a requester-1 packet
    clear_gen();
    en[1] = 1; rem[1] = 4; base[1] = 8'h30;
    repeat (4) cyc(0, 1);
    cyc(1, 1);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    rem[1] = 2; base[1] = 8'h50; bc[1] = '0;
    out_q.delete();
    gq.delete();
    for (int c = 0; c < 20 && out_q.size() < 2; c++) cyc(0, 1);
    chk("rst_new_beats", 32'(out_q.size()), 32'd2);
    if (out_q.size() >= 2) begin
      chk("rst_beat0", 32'(out_q[0]), 32'h50);
      chk("rst_beat1", 32'(out_q[1]), 32'h51);
    end
    chk("rst_first_grant", 32'(gq.size() > 0 ? gq[0] : -1), 32'd1);
    chk("rst_pkt_done", 32'(pkt_count), 32'd1);
    // random traffic against the model
    clear_gen();
    cyc(1, 1);
    for (int c = 0; c < 3000; c++) begin
      foreach (en[i]) begin
        en[i] = ($urandom % 4) != 0;
        if (rem[i] == 0 && ($urandom % 3) == 0) rem[i] = $urandom_range(1, 4);
      end
      cyc(($urandom % 300) == 0, ($urandom % 4) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
